// File: rtl/kernel_launch_queue.sv
// Kernel launch scheduler: buffers host descriptors in a small FIFO and walks each one
// through the dispatch unit (reset, start, wait for done, retire), with an abort/flush path.
module kernel_launch_queue #(
  parameter int QUEUE_DEPTH  = 4,
  parameter int TC_WIDTH     = 16,
  parameter int PC_WIDTH     = 8,
  parameter int RESET_CYCLES = 2
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             push_valid,
  output logic                             push_ready,
  input  logic [TC_WIDTH-1:0]              push_thread_count,
  input  logic [PC_WIDTH-1:0]              push_base_pc,
  input  logic                             abort,
  output logic                             dispatch_reset,
  output logic                             dispatch_start,
  output logic [TC_WIDTH-1:0]              dispatch_thread_count,
  output logic [PC_WIDTH-1:0]              dispatch_base_pc,
  input  logic                             dispatch_done,
  output logic                             kernel_done,
  output logic [7:0]                       kernels_retired,
  output logic [$clog2(QUEUE_DEPTH):0]     queue_count,
  output logic                             busy,
  output logic [1:0]                       fsm_state
);

  localparam int AW  = $clog2(QUEUE_DEPTH);
  localparam int CW  = AW + 1;
  localparam int RCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RCW-1:0] RST_LAST = RCW'(RESET_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RST    = 2'd1,
    S_RUN    = 2'd2,
    S_RETIRE = 2'd3
  } state_t;

  state_t             state, state_next;
  logic [RCW-1:0]     rst_cnt, rst_cnt_next;
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count;
  logic               full, do_push, do_pop;
  logic [TC_WIDTH-1:0] tc_mem [QUEUE_DEPTH];
  logic [PC_WIDTH-1:0] pc_mem [QUEUE_DEPTH];

  // Host handshake: a descriptor transfers on a rising clk edge where push_valid && push_ready;
  // the host holds fields stable while valid is high and not yet accepted. abort drops ready.
  assign full       = (count == CW'(QUEUE_DEPTH));
  assign push_ready = !full && !abort;
  assign do_push    = push_valid && push_ready;

  assign queue_count = count;
  assign busy        = (state != S_IDLE) || (count != '0);
  assign fsm_state   = state;

  always_comb begin
    state_next   = state;
    rst_cnt_next = rst_cnt;
    do_pop       = 1'b0;
    if (abort) begin
      state_next   = S_IDLE;
      rst_cnt_next = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (count != '0) begin
            do_pop       = 1'b1;
            rst_cnt_next = '0;
            // A zero-thread kernel has nothing to run, so it retires without a start.
            state_next   = (tc_mem[rd_ptr] == '0) ? S_RETIRE : S_RST;
          end
        end
        S_RST: begin
          if (rst_cnt == RST_LAST) begin
            state_next   = S_RUN;
            rst_cnt_next = '0;
          end else begin
            rst_cnt_next = rst_cnt + RCW'(1);
          end
        end
        S_RUN: begin
          if (dispatch_done) state_next = S_RETIRE;
        end
        S_RETIRE: state_next = S_IDLE;
        default:  state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      tc_mem[wr_ptr] <= push_thread_count;
      pc_mem[wr_ptr] <= push_base_pc;
    end
  end

  // Dispatch controls are registered from the next state so they line up with the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                 <= S_IDLE;
      rst_cnt               <= '0;
      wr_ptr                <= '0;
      rd_ptr                <= '0;
      count                 <= '0;
      dispatch_reset        <= 1'b1;
      dispatch_start        <= 1'b0;
      dispatch_thread_count <= '0;
      dispatch_base_pc      <= '0;
      kernel_done           <= 1'b0;
      kernels_retired       <= '0;
    end else begin
      state          <= state_next;
      rst_cnt        <= rst_cnt_next;
      dispatch_reset <= (state_next != S_RUN);
      dispatch_start <= (state_next == S_RUN);
      kernel_done    <= (state_next == S_RETIRE);
      if (state_next == S_RETIRE) kernels_retired <= kernels_retired + 8'd1;
      if (do_pop) begin
        dispatch_thread_count <= tc_mem[rd_ptr];
        dispatch_base_pc      <= pc_mem[rd_ptr];
      end
      if (abort) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
        case ({do_push, do_pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule
